// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, operator/category encodings
// and the per-opcode control decoder used by the decode stage.
package mips_defines;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [7:0] OPR_NONE = 8'b00000000;
  localparam logic [7:0] OPR_AND  = 8'b00100100;
  localparam logic [7:0] OPR_OR   = 8'b00100101;
  localparam logic [7:0] OPR_XOR  = 8'b00100110;
  localparam logic [7:0] OPR_NOR  = 8'b00100111;
  localparam logic [7:0] OPR_LW   = 8'b11100011;

  localparam logic [2:0] CAT_NONE  = 3'b000;
  localparam logic [2:0] CAT_LOGIC = 3'b001;
  localparam logic [2:0] CAT_LDST  = 3'b111;

  typedef enum logic [1:0] {
    IMM_ZERO = 2'd0,
    IMM_ZEXT = 2'd1,
    IMM_SEXT = 2'd2,
    IMM_LUI  = 2'd3
  } imm_kind_e;

  typedef struct packed {
    logic       rd_en_a;
    logic       rd_en_b;
    logic       we;
    logic       wsel_rd;
    logic       illegal;
    logic [7:0] operator;
    logic [2:0] category;
    imm_kind_e  imm_kind;
  } decode_ctrl_t;

  function automatic decode_ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    decode_ctrl_t c;
    c = '0;
    case (opcode)
      OP_ORI, OP_ANDI, OP_XORI: begin
        c.rd_en_a  = 1'b1;
        c.we       = 1'b1;
        c.category = CAT_LOGIC;
        c.imm_kind = IMM_ZEXT;
        c.operator = (opcode == OP_ORI)  ? OPR_OR  :
                     (opcode == OP_ANDI) ? OPR_AND : OPR_XOR;
      end
      OP_LUI: begin
        c.we       = 1'b1;
        c.category = CAT_LOGIC;
        c.imm_kind = IMM_LUI;
        c.operator = OPR_OR;
      end
      OP_LW: begin
        c.rd_en_a  = 1'b1;
        c.we       = 1'b1;
        c.category = CAT_LDST;
        c.imm_kind = IMM_SEXT;
        c.operator = OPR_LW;
      end
      OP_SPECIAL: begin
        case (funct)
          FN_AND:  c.operator = OPR_AND;
          FN_OR:   c.operator = OPR_OR;
          FN_XOR:  c.operator = OPR_XOR;
          FN_NOR:  c.operator = OPR_NOR;
          default: c.illegal  = 1'b1;
        endcase
        if (!c.illegal) begin
          c.rd_en_a  = 1'b1;
          c.rd_en_b  = 1'b1;
          c.we       = 1'b1;
          c.wsel_rd  = 1'b1;
          c.category = CAT_LOGIC;
        end else begin
          c.category = CAT_NONE;
        end
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch, register-file, forwarding and execute-side signals of the decode stage.
interface decode_stage_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int FWD_PORTS       = 2,
  parameter int STALL_CNT_WIDTH = 16
) ();
  logic                            in_valid;
  logic                            in_ready;
  logic [31:0]                     in_pc;
  logic [31:0]                     in_instruction;
  logic                            register_read_enable_a;
  logic                            register_read_enable_b;
  logic [ADDR_WIDTH-1:0]           register_read_address_a;
  logic [ADDR_WIDTH-1:0]           register_read_address_b;
  logic [DATA_WIDTH-1:0]           register_read_data_a;
  logic [DATA_WIDTH-1:0]           register_read_data_b;
  logic [FWD_PORTS-1:0]            fwd_valid;
  logic [FWD_PORTS*ADDR_WIDTH-1:0] fwd_address;
  logic [FWD_PORTS*DATA_WIDTH-1:0] fwd_data;
  logic [FWD_PORTS-1:0]            fwd_is_load;
  logic                            out_valid;
  logic                            out_ready;
  logic [31:0]                     out_pc;
  logic [7:0]                      out_operator;
  logic [2:0]                      out_category;
  logic [DATA_WIDTH-1:0]           out_operand_a;
  logic [DATA_WIDTH-1:0]           out_operand_b;
  logic                            out_write_enable;
  logic [ADDR_WIDTH-1:0]           out_write_address;
  logic                            out_illegal;
  logic [STALL_CNT_WIDTH-1:0]      stall_count;

  modport master (
    output in_valid, in_pc, in_instruction,
    output register_read_data_a, register_read_data_b,
    output fwd_valid, fwd_address, fwd_data, fwd_is_load,
    output out_ready,
    input  in_ready, register_read_enable_a, register_read_enable_b,
    input  register_read_address_a, register_read_address_b,
    input  out_valid, out_pc, out_operator, out_category, out_operand_a, out_operand_b,
    input  out_write_enable, out_write_address, out_illegal, stall_count
  );

  modport slave (
    input  in_valid, in_pc, in_instruction,
    input  register_read_data_a, register_read_data_b,
    input  fwd_valid, fwd_address, fwd_data, fwd_is_load,
    input  out_ready,
    output in_ready, register_read_enable_a, register_read_enable_b,
    output register_read_address_a, register_read_address_b,
    output out_valid, out_pc, out_operator, out_category, out_operand_a, out_operand_b,
    output out_write_enable, out_write_address, out_illegal, stall_count
  );
endinterface

// File: rtl/decode_stage_operand_forward.sv
// One operand port: priority forwarding mux over the bypass sources plus load-use hazard flag.
module operand_forward #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FWD_PORTS  = 2
) (
  input  logic                            i_read_enable,
  input  logic [ADDR_WIDTH-1:0]           i_address,
  input  logic [DATA_WIDTH-1:0]           i_rf_data,
  input  logic [DATA_WIDTH-1:0]           i_default,
  input  logic [FWD_PORTS-1:0]            i_fwd_valid,
  input  logic [FWD_PORTS*ADDR_WIDTH-1:0] i_fwd_address,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0] i_fwd_data,
  input  logic [FWD_PORTS-1:0]            i_fwd_is_load,
  output logic [DATA_WIDTH-1:0]           o_operand,
  output logic                            o_hazard
);

  logic [FWD_PORTS-1:0]  w_match;
  logic                  w_hit;
  logic                  w_sel_load;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Match each source; entries targeting register zero never match.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < FWD_PORTS; i++) begin
      w_match[i] = i_fwd_valid[i]
                && (i_fwd_address[i*ADDR_WIDTH +: ADDR_WIDTH] == i_address)
                && (i_fwd_address[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
    end
  end

  // Walk oldest to youngest so the lowest-index match is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_sel_load = 1'b0;
    w_sel_data = i_rf_data;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      w_hit      = w_match[i] ? 1'b1                                   : w_hit;
      w_sel_load = w_match[i] ? i_fwd_is_load[i]                       : w_sel_load;
      w_sel_data = w_match[i] ? i_fwd_data[i*DATA_WIDTH +: DATA_WIDTH] : w_sel_data;
    end
  end

  assign o_operand = !i_read_enable     ? i_default :
                     (i_address == '0)  ? '0        : w_sel_data;

  assign o_hazard = i_read_enable && (i_address != '0) && w_hit && w_sel_load;

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: decode, operand forwarding, load-use stall and
// a registered ID/EX output behind a valid/ready handshake.
module decode_stage
  import mips_defines::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int FWD_PORTS       = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

  logic [5:0]            w_opcode;
  logic [5:0]            w_funct;
  logic [15:0]           w_imm;
  decode_ctrl_t          w_ctrl;
  logic [ADDR_WIDTH-1:0] w_addr_a;
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_imm_ext;
  logic [DATA_WIDTH-1:0] w_operand_a;
  logic [DATA_WIDTH-1:0] w_operand_b;
  logic                  w_hazard_a;
  logic                  w_hazard_b;
  logic                  w_hazard;
  logic                  w_advance;
  logic                  w_accept;

  logic                       r_out_valid;
  logic [31:0]                r_pc;
  logic [7:0]                 r_operator;
  logic [2:0]                 r_category;
  logic [DATA_WIDTH-1:0]      r_operand_a;
  logic [DATA_WIDTH-1:0]      r_operand_b;
  logic                       r_write_enable;
  logic [ADDR_WIDTH-1:0]      r_write_address;
  logic                       r_illegal;
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;

  assign w_opcode  = bus.in_instruction[31:26];
  assign w_funct   = bus.in_instruction[5:0];
  assign w_imm     = bus.in_instruction[15:0];
  assign w_ctrl    = decode_ctrl(w_opcode, w_funct);
  assign w_addr_a  = ADDR_WIDTH'(bus.in_instruction[25:21]);
  assign w_addr_b  = ADDR_WIDTH'(bus.in_instruction[20:16]);
  assign w_wr_addr = w_ctrl.illegal ? '0 :
                     w_ctrl.wsel_rd ? ADDR_WIDTH'(bus.in_instruction[15:11]) : w_addr_b;

  // Immediate formation; this is also operand B whenever port B is not read.
  always_comb begin
    w_imm_ext = '0;
    case (w_ctrl.imm_kind)
      IMM_ZEXT: w_imm_ext = DATA_WIDTH'(w_imm);
      IMM_SEXT: w_imm_ext = DATA_WIDTH'($signed(w_imm));
      IMM_LUI:  w_imm_ext = DATA_WIDTH'({w_imm, 16'h0000});
      IMM_ZERO: w_imm_ext = '0;
      default:  w_imm_ext = '0;
    endcase
  end

  operand_forward #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FWD_PORTS(FWD_PORTS)
  ) u_forward_a (
    .i_read_enable (w_ctrl.rd_en_a),
    .i_address     (w_addr_a),
    .i_rf_data     (bus.register_read_data_a),
    .i_default     ({DATA_WIDTH{1'b0}}),
    .i_fwd_valid   (bus.fwd_valid),
    .i_fwd_address (bus.fwd_address),
    .i_fwd_data    (bus.fwd_data),
    .i_fwd_is_load (bus.fwd_is_load),
    .o_operand     (w_operand_a),
    .o_hazard      (w_hazard_a)
  );

  operand_forward #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FWD_PORTS(FWD_PORTS)
  ) u_forward_b (
    .i_read_enable (w_ctrl.rd_en_b),
    .i_address     (w_addr_b),
    .i_rf_data     (bus.register_read_data_b),
    .i_default     (w_imm_ext),
    .i_fwd_valid   (bus.fwd_valid),
    .i_fwd_address (bus.fwd_address),
    .i_fwd_data    (bus.fwd_data),
    .i_fwd_is_load (bus.fwd_is_load),
    .o_operand     (w_operand_b),
    .o_hazard      (w_hazard_b)
  );

  assign w_hazard  = w_hazard_a | w_hazard_b;
  assign w_advance = !r_out_valid || bus.out_ready;
  assign w_accept  = bus.in_valid && !w_hazard;

  // Handshake and read enables are forced low for as long as reset is held.
  assign bus.in_ready                = reset && w_advance && !w_hazard;
  assign bus.register_read_enable_a  = reset && w_ctrl.rd_en_a;
  assign bus.register_read_enable_b  = reset && w_ctrl.rd_en_b;
  assign bus.register_read_address_a = w_addr_a;
  assign bus.register_read_address_b = w_addr_b;

  // ID/EX register: a hazard on advance leaves a bubble, backpressure holds everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid     <= 1'b0;
      r_pc            <= 32'h0000_0000;
      r_operator      <= 8'h00;
      r_category      <= 3'b000;
      r_operand_a     <= '0;
      r_operand_b     <= '0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_illegal       <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_pc            <= bus.in_pc;
        r_operator      <= w_ctrl.operator;
        r_category      <= w_ctrl.category;
        r_operand_a     <= w_operand_a;
        r_operand_b     <= w_operand_b;
        r_write_enable  <= w_ctrl.we;
        r_write_address <= w_wr_addr;
        r_illegal       <= w_ctrl.illegal;
      end
    end
  end

  // Saturating count of cycles lost to load-use hazards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (bus.in_valid && w_hazard && w_advance && (r_stall_count != STALL_MAX)) begin
      r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid         = r_out_valid;
  assign bus.out_pc            = r_pc;
  assign bus.out_operator      = r_operator;
  assign bus.out_category      = r_category;
  assign bus.out_operand_a     = r_operand_a;
  assign bus.out_operand_b     = r_operand_b;
  assign bus.out_write_enable  = r_write_enable;
  assign bus.out_write_address = r_write_address;
  assign bus.out_illegal       = r_illegal;
  assign bus.stall_count       = r_stall_count;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, expected results queued
// at acceptance and checked by a monitor whenever execute takes an output.
module tb_decode_stage;

  logic clock;
  logic reset;

  decode_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FWD_PORTS(2), .STALL_CNT_WIDTH(16)) bus ();

  decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FWD_PORTS(2), .STALL_CNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [2:0]  cat;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic [4:0]  wa;
    logic        ill;
    logic        full;
  } exp_t;

  exp_t sb[$];
  exp_t m_exp;
  int   total = 0;
  int   bad   = 0;
  int   waited;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: register r holds 0x1000_0000 + r.
  assign bus.register_read_data_a = 32'h1000_0000 | {27'd0, bus.register_read_address_a};
  assign bus.register_read_data_b = 32'h1000_0000 | {27'd0, bus.register_read_address_b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] op, input logic [2:0] cat,
                              input logic [31:0] a, input logic [31:0] b, input logic we,
                              input logic [4:0] wa, input logic ill, input logic full);
    exp_t e;
    e.pc = pc; e.op = op; e.cat = cat; e.a = a; e.b = b;
    e.we = we; e.wa = wa; e.ill = ill; e.full = full;
    return e;
  endfunction

  task automatic set_fwd(input int p, input logic v, input logic [4:0] addr,
                         input logic [31:0] data, input logic ld);
    bus.fwd_valid[p]          = v;
    bus.fwd_address[p*5 +: 5] = addr;
    bus.fwd_data[p*32 +: 32]  = data;
    bus.fwd_is_load[p]        = ld;
  endtask

  task automatic clr_fwd();
    bus.fwd_valid   = 2'b00;
    bus.fwd_address = 10'd0;
    bus.fwd_data    = 64'd0;
    bus.fwd_is_load = 2'b00;
  endtask

  // Present one instruction, wait (bounded) for acceptance, queue its expectation.
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input exp_t e,
                       output int n);
    bus.in_valid       = 1'b1;
    bus.in_pc          = pc;
    bus.in_instruction = instr;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("issue_accept", {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready) sb.push_back(e);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every transfer to execute is compared against the oldest expectation.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual_pc=%h required=no_output", bus.out_pc);
      end else begin
        m_exp = sb.pop_front();
        chk("out_pc",       bus.out_pc,                  m_exp.pc);
        chk("out_operator", {24'd0, bus.out_operator},   {24'd0, m_exp.op});
        chk("out_category", {29'd0, bus.out_category},   {29'd0, m_exp.cat});
        chk("out_we",       {31'd0, bus.out_write_enable}, {31'd0, m_exp.we});
        chk("out_illegal",  {31'd0, bus.out_illegal},    {31'd0, m_exp.ill});
        chk("out_operand_a", bus.out_operand_a,          m_exp.a);
        if (m_exp.full) begin
          chk("out_operand_b", bus.out_operand_b,             m_exp.b);
          chk("out_wr_addr",   {27'd0, bus.out_write_address}, {27'd0, m_exp.wa});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_pc          = 32'd0;
    bus.in_instruction = 32'd0;
    bus.out_ready      = 1'b1;
    clr_fwd();

    // Reset state (instruction word 0 decodes as SPECIAL, so read enables must be masked)
    repeat (3) @(negedge clock);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst_rd_en_a",   {31'd0, bus.register_read_enable_a}, 32'd0);
    chk("rst_rd_en_b",   {31'd0, bus.register_read_enable_b}, 32'd0);
    chk("rst_pc",        bus.out_pc, 32'd0);
    chk("rst_operand_a", bus.out_operand_a, 32'd0);
    chk("rst_operand_b", bus.out_operand_b, 32'd0);
    chk("rst_stall",     {16'd0, bus.stall_count}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // ORI $1,$0,0x1234 in the first cycle after reset
    issue(32'h100, 32'h3401_1234, mk(32'h100, 8'b00100101, 3'b001, 32'h0, 32'h1234, 1'b1, 5'd1, 1'b0, 1'b1), waited);
    chk("ori_first_cycle", waited, 32'd0);

    // OR $3,$1,$2: EX source beats MEM source for $1, $2 from register file
    set_fwd(0, 1'b1, 5'd1, 32'hAAAA_0000, 1'b0);
    set_fwd(1, 1'b1, 5'd1, 32'h0000_5555, 1'b0);
    issue(32'h104, 32'h0022_1825, mk(32'h104, 8'b00100101, 3'b001, 32'hAAAA_0000, 32'h1000_0002, 1'b1, 5'd3, 1'b0, 1'b1), waited);
    clr_fwd();

    // Load-use: LW to $4 in EX, then ORI $5,$4,1
    set_fwd(0, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1);
    bus.in_valid       = 1'b1;
    bus.in_pc          = 32'h108;
    bus.in_instruction = 32'h3485_0001;
    @(negedge clock);
    chk("hazard_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clock);
    #1;
    set_fwd(0, 1'b1, 5'd4, 32'h0000_F0F0, 1'b0);
    @(negedge clock);
    chk("hazard_bubble",   {31'd0, bus.out_valid}, 32'd0);
    chk("hazard_stall",    {16'd0, bus.stall_count}, 32'd1);
    chk("hazard_cleared",  {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready) sb.push_back(mk(32'h108, 8'b00100101, 3'b001, 32'h0000_F0F0, 32'h1, 1'b1, 5'd5, 1'b0, 1'b1));
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    clr_fwd();

    // Backpressure: ANDI $6,$1,0xFF held for 3 cycles while XORI $7,$2,0xFFFF waits
    issue(32'h10C, 32'h3026_00FF, mk(32'h10C, 8'b00100100, 3'b001, 32'h1000_0001, 32'hFF, 1'b1, 5'd6, 1'b0, 1'b1), waited);
    bus.out_ready      = 1'b0;
    bus.in_valid       = 1'b1;
    bus.in_pc          = 32'h110;
    bus.in_instruction = 32'h3847_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out_pc",    bus.out_pc, 32'h10C);
      chk("bp_operand_a", bus.out_operand_a, 32'h1000_0001);
      chk("bp_stall",     {16'd0, bus.stall_count}, 32'd1);
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    issue(32'h110, 32'h3847_FFFF, mk(32'h110, 8'b00100110, 3'b001, 32'h1000_0002, 32'hFFFF, 1'b1, 5'd7, 1'b0, 1'b1), waited);
    chk("bp_release_issue", waited, 32'd0);

    // ORI $8,$0,7 with a load forwarding to $0: operand 0, no hazard
    set_fwd(0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    issue(32'h114, 32'h3408_0007, mk(32'h114, 8'b00100101, 3'b001, 32'h0, 32'h7, 1'b1, 5'd8, 1'b0, 1'b1), waited);
    chk("zero_no_hazard", waited, 32'd0);
    chk("zero_stall",     {16'd0, bus.stall_count}, 32'd1);
    clr_fwd();

    // XOR $12,$2,$2: younger non-load shadows an older load on $2
    set_fwd(0, 1'b1, 5'd2, 32'h0000_0022, 1'b0);
    set_fwd(1, 1'b1, 5'd2, 32'h1234_5678, 1'b1);
    issue(32'h118, 32'h0042_6026, mk(32'h118, 8'b00100110, 3'b001, 32'h22, 32'h22, 1'b1, 5'd12, 1'b0, 1'b1), waited);
    chk("shadow_no_hazard", waited, 32'd0);
    clr_fwd();

    // NOR $9,$3,$0 / LW $10,-4($1) / LUI $11,0xBEEF
    issue(32'h11C, 32'h0060_4827, mk(32'h11C, 8'b00100111, 3'b001, 32'h1000_0003, 32'h0, 1'b1, 5'd9, 1'b0, 1'b1), waited);
    issue(32'h120, 32'h8C2A_FFFC, mk(32'h120, 8'b11100011, 3'b111, 32'h1000_0001, 32'hFFFF_FFFC, 1'b1, 5'd10, 1'b0, 1'b1), waited);
    issue(32'h124, 32'h3C0B_BEEF, mk(32'h124, 8'b00100101, 3'b001, 32'h0, 32'hBEEF_0000, 1'b1, 5'd11, 1'b0, 1'b1), waited);

    // Illegal opcode 6'b111111
    issue(32'h128, 32'hFC00_0000, mk(32'h128, 8'h00, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0), waited);

    // Hold an ORI $13 under backpressure, then pull reset mid-cycle
    issue(32'h12C, 32'h340D_0001, mk(32'h12C, 8'b00100101, 3'b001, 32'h0, 32'h1, 1'b1, 5'd13, 1'b0, 1'b1), waited);
    bus.out_ready = 1'b0;
    @(negedge clock);
    chk("held_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_stall",     {16'd0, bus.stall_count}, 32'd0);
    chk("midrst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_pc",        bus.out_pc, 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode stage for the MIPS pipeline. Decodes one instruction per cycle into operator/category/operands, resolves operands from the register file or from N priority-ordered forwarding sources, detects load-use hazards and stalls upstream, and holds its results in a registered ID/EX output with a valid/ready handshake. Sits between the fetch stage and the execute stage.

## Interface
- DATA_WIDTH, 32, register and operand width (≥ 32)
- ADDR_WIDTH, 5, register address width
- FWD_PORTS, 2, number of forwarding sources; index 0 is youngest (EX), highest priority
- STALL_CNT_WIDTH, 16, width of stall performance counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  32  program counter of the instruction
- in_instruction  in  32  instruction word
- register_read_enable_a / _b  out  1  register file read enables
- register_read_address_a / _b  out  ADDR_WIDTH  = instruction[25:21] / [20:16]
- register_read_data_a / _b  in  DATA_WIDTH  combinational register file data
- fwd_valid  in  FWD_PORTS  source i writes a register
- fwd_address  in  FWD_PORTS*ADDR_WIDTH  destination of source i
- fwd_data  in  FWD_PORTS*DATA_WIDTH  result of source i
- fwd_is_load  in  FWD_PORTS  source i is a load; its data is not yet available
- out_valid  out  1  registered decoded instruction valid
- out_ready  in  1  execute accepts it
- out_pc  out  32; out_operator  out  8; out_category  out  3
- out_operand_a / out_operand_b  out  DATA_WIDTH
- out_write_enable  out  1; out_write_address  out  ADDR_WIDTH
- out_illegal  out  1  opcode not supported
- stall_count  out  STALL_CNT_WIDTH  cycles lost to load-use hazard, saturating

## Operation
- Decode (opcode [31:26]; funct [5:0] for SPECIAL):
  - ORI/ANDI/XORI: read A; operand_b = zero-extended imm; write rt
  - LUI: no reads; operand_a = 0; operand_b = imm << 16; operator OR; write rt
  - SPECIAL AND/OR/XOR/NOR: read A and B; write rd
  - LW: read A; operand_b = sign-extended imm; category load/store; write rt
  - Other: out_illegal = 1, write_enable 0, operator/category 0, reads disabled
- Operand resolution per port, when read enabled:
  - address 0 → 0
  - else lowest index i with fwd_valid[i] and fwd_address[i] == address → fwd_data[i]
  - else register file data
  - Read disabled → 0 (A) or immediate (B)
- Forwarding entries with address 0 are ignored.
- Load-use hazard: a read-enabled, nonzero address whose highest-priority match has fwd_is_load = 1. Lower-priority load matches are shadowed by a younger non-load match and cause no hazard.
- advance = !out_valid || out_ready
- in_ready = advance && !hazard
- On advance:
  - out_valid <= in_valid && !hazard
  - payload loads only when in_valid && !hazard, otherwise holds
  - a hazard therefore inserts a bubble
- stall_count increments each cycle with in_valid && hazard && advance and saturates at all-ones.
- hazard and in_ready are computed even while in_valid = 0; stall_count does not increment in that case.

## Timing
- Latency: 1 cycle, from accepted input to out_valid.
- Throughput: 1 per cycle absent hazard and backpressure.
- Register file read and forwarding mux are combinational within the input cycle.
- Backpressure (out_valid && !out_ready): all outputs hold, in_ready = 0.
- Hazard and backpressure together: hold, no bubble, stall_count unchanged.
- Reset asserted:
  - out_valid = 0, all out_* payload = 0, stall_count = 0
  - in_ready = 0 and read enables = 0 while reset is low
- Reset mid-operation discards the held instruction.
- First acceptance is possible in the first cycle after reset deasserts.

## Structure
- Package mips_defines: opcode/funct constants, 8-bit operator codes (OR 8'b00100101, AND 8'b00100100, XOR 8'b00100110, NOR 8'b00100111, LW 8'b11100011) and 3-bit category codes (logic 3'b001, load/store 3'b111).
- One sub-module, operand_forward: per-port priority mux plus hazard flag, instantiated twice (A, B).

## Test plan
- ORI $1,$0,0x1234, no forwarding, out_ready = 1 → next cycle: out_valid, operator 8'b00100101, operand_a 0, operand_b 0x00001234, write_enable 1, write_address 1.
- OR $3,$1,$2 with fwd[0]={$1,0xAAAA0000} and fwd[1]={$1,0x5555} → operand_a 0xAAAA0000 (priority); $2 taken from the register file.
- LW in EX (fwd_is_load[0] = 1, address 4), then ORI $5,$4,1:
  - 1 cycle with in_ready = 0 and a bubble (out_valid 0); stall_count = 1
  - the instruction issues when the load clears
- out_ready held low 3 cycles with a valid output → outputs stable, in_ready = 0, stall_count unchanged; the next instruction issues on the release cycle.
- Read of $0 while fwd[0] = {$0,0xFFFFFFFF} → operand 0, no hazard even with is_load.
- Illegal opcode 6'b111111 → out_illegal 1, write_enable 0; then reset pulled low mid-stream → out_valid 0 and stall_count 0 immediately.
